// File: rtl/spi_cmd_parser.sv
// spi_cmd_parser: decodes 5-byte SPI frames (CMD, ADDR_H, ADDR_L, DATA_H, DATA_L) into register write/read strobes
module spi_cmd_parser #(
  parameter logic [7:0] CMD_WR     = 8'h80,
  parameter logic [7:0] CMD_RD     = 8'h81,
  parameter int         RD_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_cs_active,
  input  logic        i_byte_valid,
  input  logic        i_frame_start,
  input  logic [7:0]  iv_byte_data,
  output logic        o_wr_en,
  output logic        o_rd_en,
  output logic [15:0] ov_addr,
  output logic [15:0] ov_wr_data,
  input  logic        i_rd_valid,
  input  logic [15:0] iv_rd_data,
  output logic        o_tx_load,
  output logic [7:0]  ov_tx_data,
  output logic        o_cmd_err
);
  localparam int CW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L, S_WAIT_RD, S_IGNORE
  } state_t;

  state_t         r_state;
  logic           r_is_rd;
  // the high read byte goes straight to the shifter, so only the low byte is held
  logic [7:0]     r_rd_lo;
  logic [CW-1:0]  r_tmo_cnt;
  logic           w_start;
  logic           w_byte;

  assign w_start = i_byte_valid & i_frame_start;
  assign w_byte  = i_byte_valid & ~i_frame_start;

  // frame FSM with registered one-clock strobes; chip-select loss beats everything but reset
  always_ff @(posedge clk) begin
    o_wr_en   <= 1'b0;
    o_rd_en   <= 1'b0;
    o_tx_load <= 1'b0;
    o_cmd_err <= 1'b0;
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_is_rd    <= 1'b0;
      r_rd_lo    <= '0;
      r_tmo_cnt  <= '0;
      ov_addr    <= '0;
      ov_wr_data <= '0;
      ov_tx_data <= '0;
    end else if (!i_cs_active) begin
      r_state <= S_IDLE;
    end else if (w_start) begin
      r_is_rd <= (iv_byte_data == CMD_RD);
      if (iv_byte_data == CMD_WR || iv_byte_data == CMD_RD) begin
        r_state <= S_ADDR_H;
      end else begin
        o_cmd_err <= 1'b1;
        r_state   <= S_IGNORE;
      end
    end else begin
      case (r_state)
        S_ADDR_H: if (w_byte) begin
          ov_addr[15:8] <= iv_byte_data;
          r_state       <= S_ADDR_L;
        end
        S_ADDR_L: if (w_byte) begin
          ov_addr[7:0] <= iv_byte_data;
          o_rd_en      <= r_is_rd;
          r_tmo_cnt    <= '0;
          r_state      <= r_is_rd ? S_WAIT_RD : S_DATA_H;
        end
        S_WAIT_RD: if (i_rd_valid) begin
          r_rd_lo    <= iv_rd_data[7:0];
          ov_tx_data <= iv_rd_data[15:8];
          o_tx_load  <= 1'b1;
          r_state    <= S_DATA_H;
        end else if (r_tmo_cnt == CW'(RD_TIMEOUT - 1)) begin
          r_rd_lo    <= '0;
          ov_tx_data <= '0;
          o_tx_load  <= 1'b1;
          o_cmd_err  <= 1'b1;
          r_state    <= S_DATA_H;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
        S_DATA_H: if (w_byte) begin
          if (r_is_rd) begin
            ov_tx_data <= r_rd_lo;
            o_tx_load  <= 1'b1;
          end else begin
            ov_wr_data[15:8] <= iv_byte_data;
          end
          r_state <= S_DATA_L;
        end
        S_DATA_L: if (w_byte) begin
          if (!r_is_rd) begin
            ov_wr_data[7:0] <= iv_byte_data;
            o_wr_en         <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_cmd_parser.sv
// tb_spi_cmd_parser: frame-level reference model feeding a scoreboard queue, monitor checks every strobe
module tb_spi_cmd_parser;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0;
  logic        bv = 1'b0;
  logic        fs = 1'b0;
  logic        rv = 1'b0;
  logic [7:0]  bd = '0;
  logic [15:0] rdat = '0;
  logic        wr_en, rd_en, tx_load, cmd_err;
  logic [15:0] addr, wr_data;
  logic [7:0]  tx_data;

  spi_cmd_parser #(.CMD_WR(8'h80), .CMD_RD(8'h81), .RD_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .i_cs_active(cs), .i_byte_valid(bv),
    .i_frame_start(fs), .iv_byte_data(bd), .o_wr_en(wr_en), .o_rd_en(rd_en),
    .ov_addr(addr), .ov_wr_data(wr_data), .i_rd_valid(rv), .iv_rd_data(rdat),
    .o_tx_load(tx_load), .ov_tx_data(tx_data), .o_cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // m = {wr, rd, tx, err}
  typedef struct packed {
    logic [3:0]  m;
    logic [15:0] a;
    logic [15:0] w;
    logic [7:0]  t;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad = 0;
  ev_t got, want;
  logic ok;

  function automatic ev_t mk(input logic [3:0] m, input logic [15:0] a, input logic [15:0] w, input logic [7:0] t);
    ev_t e;
    e.m = m; e.a = a; e.w = w; e.t = t;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp_v);
    end
  endtask

  // monitor: any strobe pops the next expected event
  initial forever begin
    @(posedge clk);
    #1;
    if (wr_en || rd_en || tx_load || cmd_err) begin
      got = mk({wr_en, rd_en, tx_load, cmd_err}, addr, wr_data, tx_data);
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe got m=%b a=%h w=%h t=%h exp none", got.m, got.a, got.w, got.t);
      end else begin
        want = q.pop_front();
        ok = (got.m == want.m) && (!want.m[3] || (got.a == want.a && got.w == want.w))
             && (!want.m[2] || got.a == want.a) && (!want.m[1] || got.t == want.t);
        if (!ok) begin
          bad++;
          $display("FAIL strobe got m=%b a=%h w=%h t=%h exp m=%b a=%h w=%h t=%h",
                   got.m, got.a, got.w, got.t, want.m, want.a, want.w, want.t);
        end
      end
    end
  end

  task automatic cyc(input logic b, input logic f, input logic [7:0] d, input logic r, input logic [15:0] rd);
    @(negedge clk);
    bv = b; fs = f; bd = d; rv = r; rdat = rd;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic f, input int gmax);
    idle(int'($urandom_range(0, gmax)));
    cyc(1'b1, f, d, 1'b0, 16'h0000);
  endtask

  // whole frame: expectations come from the frame contents, then the bytes are driven
  task automatic frame(input logic [7:0] cmd, input logic [15:0] a, input logic [15:0] d,
                       input int lat, input int gmax, input int extra);
    if (cmd == 8'h80) q.push_back(mk(4'b1000, a, d, 8'h00));
    else if (cmd == 8'h81) begin
      q.push_back(mk(4'b0100, a, 16'h0, 8'h00));
      if (lat <= TMO) begin
        q.push_back(mk(4'b0010, a, 16'h0, d[15:8]));
        q.push_back(mk(4'b0010, a, 16'h0, d[7:0]));
      end else begin
        q.push_back(mk(4'b0011, a, 16'h0, 8'h00));
        q.push_back(mk(4'b0010, a, 16'h0, 8'h00));
      end
    end else q.push_back(mk(4'b0001, a, 16'h0, 8'h00));
    send_byte(cmd, 1'b1, gmax);
    send_byte(a[15:8], 1'b0, gmax);
    send_byte(a[7:0], 1'b0, gmax);
    if (cmd == 8'h81) begin
      if (lat <= TMO) begin
        idle(lat - 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, d);
      end else begin
        idle(TMO);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, d);
      end
      idle(1);
      send_byte(8'h00, 1'b0, gmax);
      send_byte(8'h00, 1'b0, gmax);
    end else begin
      send_byte(d[15:8], 1'b0, gmax);
      send_byte(d[7:0], 1'b0, gmax);
    end
    for (int i = 0; i < extra; i++) send_byte(8'($urandom), 1'b0, gmax);
    idle(2);
  endtask

  initial begin
    logic [7:0] c;
    int k;
    idle(3);
    @(posedge clk);
    #1;
    chk("rst_wr_en", {31'd0, wr_en}, 0);
    chk("rst_rd_en", {31'd0, rd_en}, 0);
    chk("rst_tx_load", {31'd0, tx_load}, 0);
    chk("rst_cmd_err", {31'd0, cmd_err}, 0);
    chk("rst_addr", {16'd0, addr}, 0);
    chk("rst_wr_data", {16'd0, wr_data}, 0);
    chk("rst_tx_data", {24'd0, tx_data}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cs = 1'b1;
    idle(2);
    frame(8'h80, 16'h0055, 16'hAB56, 0, 0, 0);
    frame(8'h81, 16'h0055, 16'hAB56, 3, 0, 0);
    frame(8'h80, 16'h0164, 16'h7488, 0, 1, 1);
    frame(8'h82, 16'h1234, 16'h5678, 0, 0, 0);
    frame(8'h81, 16'h00B4, 16'hABCD, TMO + 1, 0, 0);
    frame(8'h81, 16'h0A0B, 16'h1357, TMO, 0, 0);
    frame(8'h81, 16'h0A0C, 16'h2468, 1, 0, 1);
    send_byte(8'h80, 1'b1, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h40, 1'b0, 0);
    idle(1);
    cs = 1'b0;
    idle(2);
    cs = 1'b1;
    send_byte(8'h48, 1'b0, 0);
    send_byte(8'h21, 1'b0, 0);
    idle(2);
    send_byte(8'h80, 1'b1, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h40, 1'b0, 0);
    send_byte(8'h48, 1'b0, 0);
    cyc(1'b1, 1'b0, 8'h21, 1'b0, 16'h0);
    cs = 1'b0;
    idle(1);
    cs = 1'b1;
    idle(2);
    send_byte(8'h80, 1'b1, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h40, 1'b0, 0);
    cyc(1'b1, 1'b0, 8'h48, 1'b0, 16'h0);
    reset_n = 1'b0;
    idle(1);
    cyc(1'b1, 1'b0, 8'h21, 1'b0, 16'h0);
    @(posedge clk);
    #1;
    chk("midrst_addr", {16'd0, addr}, 0);
    chk("midrst_wr_data", {16'd0, wr_data}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bv = 1'b0;
    send_byte(8'h21, 1'b0, 0);
    idle(2);
    send_byte(8'h80, 1'b1, 0);
    send_byte(8'h12, 1'b0, 0);
    frame(8'h80, 16'h0040, 16'h4821, 0, 0, 0);
    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(0, 2));
      if (k == 2) begin
        c = 8'($urandom);
        while (c == 8'h80 || c == 8'h81) c = 8'($urandom);
      end else c = (k == 0) ? 8'h80 : 8'h81;
      frame(c, 16'($urandom), 16'($urandom), int'($urandom_range(1, TMO + 3)), 2, int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) begin
        cs = 1'b0;
        idle(1);
        cs = 1'b1;
        idle(1);
      end
    end
    idle(10);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
